// File: rtl/wb_stage_pipe_if.sv
// Writeback stage bus: memory-stage instruction fields,
// read response, stall back-pressure and regfile write port.
interface wb_stage_pipe_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  localparam int OFF_W = $clog2(XLEN/8);

  logic              valid_i;
  logic              RegWrite_i;
  logic [1:0]        WriteSrc_i;
  logic [2:0]        LoadType_i;
  logic [OFF_W-1:0]  ByteOff_i;
  logic [XLEN-1:0]   ALUout_i;
  logic [XLEN-1:0]   pcPlus4_i;
  logic [XLEN-1:0]   ImmOp_i;
  logic [REG_AW-1:0] rd_i;
  logic              MemRValid_i;
  logic [XLEN-1:0]   DataMemOut_i;
  logic              stall_o;
  logic              RegWrite_o;
  logic [REG_AW-1:0] rd_o;
  logic [XLEN-1:0]   WD3_o;

  modport master (
    output valid_i, RegWrite_i, WriteSrc_i,
    output LoadType_i, ByteOff_i, ALUout_i,
    output pcPlus4_i, ImmOp_i, rd_i,
    output MemRValid_i, DataMemOut_i,
    input  stall_o, RegWrite_o, rd_o, WD3_o
  );

  modport slave (
    input  valid_i, RegWrite_i, WriteSrc_i,
    input  LoadType_i, ByteOff_i, ALUout_i,
    input  pcPlus4_i, ImmOp_i, rd_i,
    input  MemRValid_i, DataMemOut_i,
    output stall_o, RegWrite_o, rd_o, WD3_o
  );
endinterface

// File: rtl/wb_stage_pipe.sv
// Registered writeback stage: source select, load extract,
// late-response wait state with stall, x0 suppression.
// Ports: clk_i, rst_i (async high), bus (wb_stage_pipe_if.slave).
module wb_stage_pipe #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input logic           clk_i,
  input logic           rst_i,
  wb_stage_pipe_if.slave bus
);
  localparam int OFF_W = $clog2(XLEN/8);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_h_we;
  logic [2:0]        r_h_lt;
  logic [OFF_W-1:0]  r_h_off;
  logic [REG_AW-1:0] r_h_rd;
  logic              r_we;
  logic [REG_AW-1:0] r_rd;
  logic [XLEN-1:0]   r_wd;

  logic              w_cmp;
  logic              w_we;
  logic              w_latch;
  logic              w_stall;
  logic [REG_AW-1:0] w_rd;
  logic [XLEN-1:0]   w_wd;
  logic [XLEN-1:0]   w_src;
  logic [XLEN-1:0]   w_ld;
  logic [2:0]        w_lt;
  logic [OFF_W-1:0]  w_off;
  logic [OFF_W-1:0]  w_hoff;
  logic [OFF_W-1:0]  w_woff;
  logic [7:0]        w_b;
  logic [15:0]       w_h;
  logic [31:0]       w_w;

  // While waiting, the held load fields steer extraction.
  assign w_lt  = (r_state == S_WAIT) ? r_h_lt  : bus.LoadType_i;
  assign w_off = (r_state == S_WAIT) ? r_h_off : bus.ByteOff_i;

  // Halfword/word lanes drop the low offset bits (no misalign check).
  assign w_hoff = w_off & ~OFF_W'(1);
  assign w_woff = w_off & ~OFF_W'(3);

  assign w_b = 8'(bus.DataMemOut_i >> {w_off, 3'b000});
  assign w_h = 16'(bus.DataMemOut_i >> {w_hoff, 3'b000});
  assign w_w = 32'(bus.DataMemOut_i >> {w_woff, 3'b000});

  always_comb begin
    w_ld = bus.DataMemOut_i;
    case (w_lt)
      3'b000: w_ld = XLEN'($signed(w_b));
      3'b001: w_ld = XLEN'($signed(w_h));
      3'b100: w_ld = XLEN'(w_b);
      3'b101: w_ld = XLEN'(w_h);
      3'b010: if (XLEN == 64) w_ld = XLEN'($signed(w_w));
      3'b110: if (XLEN == 64) w_ld = XLEN'(w_w);
      default: w_ld = bus.DataMemOut_i;
    endcase
  end

  always_comb begin
    w_src = bus.ALUout_i;
    unique case (bus.WriteSrc_i)
      2'd0: w_src = bus.ALUout_i;
      2'd1: w_src = w_ld;
      2'd2: w_src = bus.pcPlus4_i;
      2'd3: w_src = bus.ImmOp_i;
    endcase
  end

  always_comb begin
    w_next  = r_state;
    w_cmp   = 1'b0;
    w_we    = bus.RegWrite_i;
    w_rd    = bus.rd_i;
    w_wd    = w_src;
    w_latch = 1'b0;
    w_stall = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.valid_i) begin
          if (bus.WriteSrc_i != 2'd1 || bus.MemRValid_i) begin
            w_cmp = 1'b1;
          end else begin
            w_stall = 1'b1;
            w_latch = 1'b1;
            w_next  = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        w_we = r_h_we;
        w_rd = r_h_rd;
        w_wd = w_ld;
        if (bus.MemRValid_i) begin
          w_cmp  = 1'b1;
          w_next = S_IDLE;
        end else begin
          w_stall = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_h_we  <= 1'b0;
      r_h_lt  <= '0;
      r_h_off <= '0;
      r_h_rd  <= '0;
    end else begin
      r_state <= w_next;
      if (w_latch) begin
        r_h_we  <= bus.RegWrite_i;
        r_h_lt  <= bus.LoadType_i;
        r_h_off <= bus.ByteOff_i;
        r_h_rd  <= bus.rd_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_we <= 1'b0;
      r_rd <= '0;
      r_wd <= '0;
    end else if (w_cmp) begin
      r_we <= w_we & (w_rd != '0);
      r_rd <= w_rd;
      r_wd <= w_wd;
    end else begin
      r_we <= 1'b0;
    end
  end

  assign bus.stall_o    = w_stall;
  assign bus.RegWrite_o = r_we;
  assign bus.rd_o       = r_rd;
  assign bus.WD3_o      = r_wd;
endmodule

// File: tb/tb_wb_stage_pipe.sv
// Bench for wb_stage_pipe: vector table, hand sequences
// for wait/reset/stray cases, random run against a model.
module tb_wb_stage_pipe;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  wb_stage_pipe_if #(.XLEN(32), .REG_AW(5)) bus ();

  wb_stage_pipe #(.XLEN(32), .REG_AW(5)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  src;
    logic [2:0]  lt;
    logic [1:0]  off;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [31:0] dm;
    logic        ewe;
    logic [31:0] ewd;
  } vec_t;

  typedef struct {
    logic       we;
    int         lt;
    int         off;
    logic [4:0] rd;
  } pend_t;

  vec_t  vt [12];
  pend_t pend [$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic we,
                        input logic [1:0] src, input logic [2:0] lt,
                        input logic [1:0] off, input logic [31:0] alu,
                        input logic [31:0] pc, input logic [31:0] imm,
                        input logic [4:0] rd, input logic mv,
                        input logic [31:0] dm);
    bus.valid_i      = v;
    bus.RegWrite_i   = we;
    bus.WriteSrc_i   = src;
    bus.LoadType_i   = lt;
    bus.ByteOff_i    = off;
    bus.ALUout_i     = alu;
    bus.pcPlus4_i    = pc;
    bus.ImmOp_i      = imm;
    bus.rd_i         = rd;
    bus.MemRValid_i  = mv;
    bus.DataMemOut_i = dm;
  endtask

  task automatic idle_in();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Reference load extraction from the RV32 load rules.
  function automatic logic [31:0] ref_ld(int lt, int off,
                                         logic [31:0] d);
    logic [31:0] v;
    int          o2;
    case (lt)
      0, 4: begin
        v = (d >> (off * 8)) & 32'hFF;
        if (lt == 0 && v >= 128) v = v - 256;
      end
      1, 5: begin
        o2 = (off / 2) * 2;
        v = (d >> (o2 * 8)) & 32'hFFFF;
        if (lt == 1 && v >= 32768) v = v - 65536;
      end
      default: v = d;
    endcase
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          cnt;
    logic        v, we, mv, cmp, ewe, est;
    logic [1:0]  src, off;
    logic [2:0]  lt;
    logic [31:0] alu, pc, imm, dm, ewd, exp_wd;
    logic [4:0]  rd, erd, exp_rd;
    pend_t       h;

    vt[0]  = '{1, 0, 0, 0, 32'h12345678, 32'h4, 32'h8, 7,
               32'h0, 1, 32'h12345678};
    vt[1]  = '{1, 1, 0, 2, 32'h1, 32'h2, 32'h3, 3,
               32'h00800000, 1, 32'hFFFFFF80};
    vt[2]  = '{1, 1, 4, 2, 32'h1, 32'h2, 32'h3, 3,
               32'h00800000, 1, 32'h00000080};
    vt[3]  = '{1, 1, 5, 2, 32'h1, 32'h2, 32'h3, 4,
               32'hBEEF0000, 1, 32'h0000BEEF};
    vt[4]  = '{1, 3, 0, 0, 32'h1, 32'h2, 32'hABC, 0,
               32'h0, 0, 32'h00000ABC};
    vt[5]  = '{1, 2, 0, 0, 32'h1, 32'h1004, 32'h3, 1,
               32'h0, 1, 32'h00001004};
    vt[6]  = '{1, 1, 1, 3, 32'h1, 32'h2, 32'h3, 8,
               32'h80010000, 1, 32'hFFFF8001};
    vt[7]  = '{1, 1, 2, 1, 32'h1, 32'h2, 32'h3, 9,
               32'hDEADBEEF, 1, 32'hDEADBEEF};
    vt[8]  = '{1, 1, 6, 2, 32'h1, 32'h2, 32'h3, 10,
               32'h12345678, 1, 32'h12345678};
    vt[9]  = '{1, 1, 0, 3, 32'h1, 32'h2, 32'h3, 11,
               32'h7F000000, 1, 32'h0000007F};
    vt[10] = '{0, 0, 0, 0, 32'h55, 32'h2, 32'h3, 4,
               32'h0, 0, 32'h00000055};
    vt[11] = '{1, 1, 3, 0, 32'h1, 32'h2, 32'h3, 13,
               32'hA5A5A5A5, 1, 32'hA5A5A5A5};

    rst = 1'b1;
    idle_in();
    #2;
    chk("rst_stall", 32'(bus.stall_o), 0);
    chk("rst_we", 32'(bus.RegWrite_o), 0);
    chk("rst_rd", 32'(bus.rd_o), 0);
    chk("rst_wd", bus.WD3_o, 0);
    #10 rst = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      set_in(1, vt[i].we, vt[i].src, vt[i].lt, vt[i].off,
             vt[i].alu, vt[i].pc, vt[i].imm, vt[i].rd, 1, vt[i].dm);
      #1;
      chk($sformatf("vec%0d_stall", i), 32'(bus.stall_o), 0);
      tick();
      chk($sformatf("vec%0d_we", i), 32'(bus.RegWrite_o),
          32'(vt[i].ewe));
      chk($sformatf("vec%0d_rd", i), 32'(bus.rd_o), 32'(vt[i].rd));
      chk($sformatf("vec%0d_wd", i), bus.WD3_o, vt[i].ewd);
      idle_in();
      tick();
      chk($sformatf("vec%0d_pulse", i), 32'(bus.RegWrite_o), 0);
    end

    // Late load: response three cycles after issue.
    set_in(1, 1, 1, 1, 0, 32'h1, 32'h2, 32'h3, 5, 0, 32'h0);
    cnt = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (bus.stall_o) cnt++;
      tick();
      chk("late_wait_we", 32'(bus.RegWrite_o), 0);
      set_in(1, 0, 0, 3'd4, 2'd3, 32'h55 + c, 32'h2, 32'h3,
             5'd9 + 5'(c), 0, 32'hFFFFFFFF);
    end
    set_in(1, 1, 0, 3'd4, 2'd3, 32'h77, 32'h2, 32'h3, 9, 1,
           32'h00008001);
    #1;
    chk("late_stall_drop", 32'(bus.stall_o), 0);
    chk("late_stall_cycles", cnt, 3);
    tick();
    idle_in();
    chk("late_we", 32'(bus.RegWrite_o), 1);
    chk("late_rd", 32'(bus.rd_o), 5);
    chk("late_wd", bus.WD3_o, 32'hFFFF8001);
    tick();
    chk("late_pulse", 32'(bus.RegWrite_o), 0);

    // Reset while a load is outstanding.
    set_in(1, 1, 1, 0, 0, 32'h1, 32'h2, 32'h3, 6, 0, 32'h0);
    tick();
    idle_in();
    #1 rst = 1'b1;
    #1;
    chk("rstw_stall", 32'(bus.stall_o), 0);
    chk("rstw_we", 32'(bus.RegWrite_o), 0);
    chk("rstw_rd", 32'(bus.rd_o), 0);
    chk("rstw_wd", bus.WD3_o, 0);
    rst = 1'b0;
    set_in(0, 1, 1, 0, 0, 32'h1, 32'h2, 32'h3, 6, 1, 32'h80);
    #1;
    chk("rstw_stall2", 32'(bus.stall_o), 0);
    tick();
    chk("rstw_nowr", 32'(bus.RegWrite_o), 0);
    chk("rstw_wd2", bus.WD3_o, 0);

    // Stray response after an ALU write; outputs must hold.
    set_in(1, 1, 0, 0, 0, 32'hCAFE, 32'h2, 32'h3, 12, 0, 32'h0);
    tick();
    set_in(0, 1, 1, 0, 0, 32'h1, 32'h2, 32'h3, 14, 1, 32'h1234);
    #1;
    chk("stray_stall", 32'(bus.stall_o), 0);
    tick();
    chk("stray_we", 32'(bus.RegWrite_o), 0);
    chk("stray_rd", 32'(bus.rd_o), 12);
    chk("stray_wd", bus.WD3_o, 32'hCAFE);

    // Random run against the reference model.
    idle_in();
    rst = 1'b1;
    #2 rst = 1'b0;
    exp_rd = 0;
    exp_wd = 0;
    pend.delete();
    tick();
    for (int i = 0; i < 400; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      we  = 1'($urandom);
      src = 2'($urandom_range(0, 3));
      lt  = 3'($urandom_range(0, 7));
      off = 2'($urandom);
      alu = $urandom;
      pc  = $urandom;
      imm = $urandom;
      dm  = $urandom;
      rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      mv  = ($urandom_range(0, 2) == 0);
      set_in(v, we, src, lt, off, alu, pc, imm, rd, mv, dm);
      cmp = 0; est = 0; ewe = 0; erd = 0; ewd = 0;
      if (pend.size() != 0) begin
        h = pend[0];
        if (mv) begin
          cmp = 1; ewe = h.we; erd = h.rd;
          ewd = ref_ld(h.lt, h.off, dm);
          void'(pend.pop_front());
        end else begin
          est = 1;
        end
      end else if (v) begin
        if (src != 1 || mv) begin
          cmp = 1; ewe = we; erd = rd;
          case (src)
            2'd0: ewd = alu;
            2'd1: ewd = ref_ld(int'(lt), int'(off), dm);
            2'd2: ewd = pc;
            default: ewd = imm;
          endcase
        end else begin
          est = 1;
          pend.push_back('{we, int'(lt), int'(off), rd});
        end
      end
      #1;
      chk("rnd_stall", 32'(bus.stall_o), 32'(est));
      tick();
      if (cmp) begin
        exp_rd = erd;
        exp_wd = ewd;
      end
      chk("rnd_we", 32'(bus.RegWrite_o),
          32'(cmp && ewe && erd != 0));
      chk("rnd_rd", 32'(bus.rd_o), 32'(exp_rd));
      chk("rnd_wd", bus.WD3_o, exp_wd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wb_stage_pipe.md
Name: wb_stage_pipe

Overview:
- Registered, parametrised writeback stage.
- Selects the register-file write value from four sources: ALU, load data, PC+4 and immediate.
- Adds behaviour the combinational writeback mux lacks:
  - load byte/halfword/word extraction with sign or zero extension;
  - a wait state for memory read responses that arrive late, with a stall back to the pipeline;
  - x0 write suppression.
- Sits between the memory stage and the register file. Its registered outputs drive register-file write port 3 and the forwarding unit.

Parameters:
- XLEN, 32: datapath width; legal values 32 or 64.
- REG_AW, 5: register address width.
- OFF_W, $clog2(XLEN/8): byte-offset width; derived, not overridden.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- valid_i  in  1  the memory-stage instruction in the input fields is valid.
- RegWrite_i  in  1  the instruction writes rd.
- WriteSrc_i  in  2  write source: 0 ALU, 1 memory, 2 PC+4, 3 immediate.
- LoadType_i  in  3  load funct3.
- ByteOff_i  in  OFF_W  address low bits of the load.
- ALUout_i  in  XLEN  ALU result.
- pcPlus4_i  in  XLEN  PC+4.
- ImmOp_i  in  XLEN  immediate.
- rd_i  in  REG_AW  destination register.
- MemRValid_i  in  1  DataMemOut_i is valid this cycle.
- DataMemOut_i  in  XLEN  raw aligned memory read word.
- stall_o  out  1  combinational; upstream must hold its inputs and not advance.
- RegWrite_o  out  1  registered write enable.
- rd_o  out  REG_AW  registered destination register.
- WD3_o  out  XLEN  registered write data.

Behaviour:
- Reset (asynchronous, any state):
  - state goes to IDLE;
  - RegWrite_o=0, rd_o=0, WD3_o=0;
  - hold registers are cleared.
- States: IDLE and WAIT_MEM.
- IDLE, valid_i=0: no write. RegWrite_o=0 on the next edge; rd_o and WD3_o hold their values.
- IDLE, valid_i=1, WriteSrc_i≠1: complete. At the next edge:
  - WD3_o = selected source;
  - rd_o = rd_i;
  - RegWrite_o = RegWrite_i & (rd_i≠0).
- IDLE, valid_i=1, WriteSrc_i=1, MemRValid_i=1: complete in the same way, using the extracted load data. Latency is 1 cycle.
- IDLE, valid_i=1, WriteSrc_i=1, MemRValid_i=0:
  - stall_o=1;
  - latch RegWrite_i, LoadType_i, ByteOff_i and rd_i into hold registers;
  - go to WAIT_MEM; RegWrite_o=0 on the next edge.
- WAIT_MEM:
  - valid_i and all instruction inputs are ignored;
  - stall_o = ~MemRValid_i;
  - on MemRValid_i=1: complete using the held fields, return to IDLE, and drop stall_o in that same cycle;
  - no timeout; the block waits indefinitely.
- stall_o equation: (IDLE & valid_i & WriteSrc_i==1 & ~MemRValid_i) | (WAIT_MEM & ~MemRValid_i).
- MemRValid_i while no load is pending (IDLE with a non-load or valid_i=0): ignored; it produces no write.
- Load extraction, with byte lane b = ByteOff × 8:
  - 000 LB: sign-extend byte [b+7:b].
  - 001 LH: sign-extend halfword at offset {ByteOff[OFF_W-1:1],0}×8. ByteOff[0] is ignored; misalignment is not detected.
  - 010 LW: XLEN=32 passes the full word. XLEN=64 sign-extends the word at ByteOff[2]×32.
  - 100 LBU / 101 LHU: as LB / LH but zero-extended.
  - 110 LWU: zero-extended word; XLEN=64 only.
  - 011 LD: full word; XLEN=64 only.
  - Any code not listed, or not legal for XLEN, is treated as a full XLEN pass-through.
- Writes to rd=0: RegWrite_o is forced to 0, but rd_o and WD3_o still update.
- RegWrite_o is a one-cycle pulse per completed instruction. Completions occur at most once per cycle.

Test Plan:
- Reset mid-wait:
  - stimulus: assert rst_i while in WAIT_MEM, then deassert; drive MemRValid_i=1 afterwards;
  - response: state IDLE, stall_o=0, all outputs 0, and no write occurs.
- ALU path:
  - stimulus: valid_i=1, WriteSrc_i=0, ALUout_i=0x1234_5678, rd_i=7, RegWrite_i=1;
  - response: next cycle RegWrite_o=1, rd_o=7, WD3_o=0x1234_5678; the following cycle RegWrite_o=0.
- Same-cycle load:
  - stimulus: LB, ByteOff=2, DataMemOut_i=0x0080_0000, MemRValid_i=1;
  - response: WD3_o=0xFFFF_FF80, stall_o never asserted.
  - LBU on the same data gives 0x0000_0080. LHU with ByteOff=2 and data 0xBEEF_0000 gives 0x0000_BEEF.
- Late load:
  - stimulus: LH, ByteOff=0, rd=5, with MemRValid_i arriving 3 cycles later carrying 0x0000_8001; inputs change during the wait;
  - response: stall_o=1 for exactly 3 cycles, then WD3_o=0xFFFF_8001 with rd_o=5 (the held rd, not the changed input).
- x0 and immediate:
  - stimulus: WriteSrc_i=3, ImmOp_i=0xABC, rd_i=0, RegWrite_i=1;
  - response: RegWrite_o=0, WD3_o=0xABC.
  - PC+4 source with rd=1 writes pcPlus4_i.
- Stray response:
  - stimulus: MemRValid_i=1 with valid_i=0;
  - response: no write, stall_o=0.
